// File: rtl/recovery_ctrl_pkg.sv
// Shared types and constants for the pipeline recovery sequencer.
// The optional performance counters are enabled with RECOVERY_PERF_EN.
// N_WAY and XLEN come from the project-wide macros; fall back to sane
// values when this slice is built on its own.
`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef XLEN
`define XLEN 32
`endif

package recovery_ctrl_pkg;

    // Encoded sequencer states; values are visible on state_dbg.
    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_FLUSH    = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_REDIRECT = 3'd3,
        ST_HALT     = 3'd4
    } recovery_state_t;

    localparam int DRAIN_CYCLES_DEFAULT = 3;

    // Bits needed to hold DRAIN_CYCLES-1 (at least one bit).
    function automatic int drain_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/recovery_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc, hold once every bit is set.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/recovery_ctrl.sv
// Pipeline recovery sequencer: flush pulse, drain stall, handshaked fetch
// redirect, and the terminal HALT state. Define RECOVERY_PERF_EN to add the
// recovery_count / stall_cycles performance counters.
module recovery_ctrl
    import recovery_ctrl_pkg::*;
#(
    parameter int N_WAY        = `N_WAY,
    parameter int XLEN         = `XLEN,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
`ifdef RECOVERY_PERF_EN
    ,
    parameter int CNT_W        = 16
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_WAY-1:0] retire_valid,
    input  logic [N_WAY-1:0] retire_halt,
    input  logic [N_WAY-1:0] retire_illegal,
    input  logic             retire_branch,
    input  logic [XLEN-1:0]  retire_branch_PC,
    input  logic             fetch_redirect_ready,
    output logic             flush,
    output logic             dispatch_stall,
    output logic             fetch_redirect_valid,
    output logic [XLEN-1:0]  fetch_redirect_pc,
    output logic             halted,
    output logic             illegal_seen,
    output logic [2:0]       state_dbg
`ifdef RECOVERY_PERF_EN
    ,
    output logic [CNT_W-1:0] recovery_count,
    output logic [CNT_W-1:0] stall_cycles
`endif
);

    localparam int DW = drain_cnt_width(DRAIN_CYCLES);

    recovery_state_t state;
    logic [DW-1:0]   drain_cnt;
    logic            halt_event;

    // Only valid lanes may raise a halt; illegal also terminates the program.
    assign halt_event = |(retire_valid & (retire_halt | retire_illegal));
    assign state_dbg  = state;

    // Sequencer with outputs registered alongside the state they belong to.
    always_ff @(posedge clock) begin
        if (reset) begin
            state                <= ST_RUN;
            flush                <= 1'b0;
            dispatch_stall       <= 1'b0;
            fetch_redirect_valid <= 1'b0;
            fetch_redirect_pc    <= '0;
            halted               <= 1'b0;
            illegal_seen         <= 1'b0;
            drain_cnt            <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    // Halt outranks a branch retiring in the same cycle.
                    if (halt_event) begin
                        state          <= ST_HALT;
                        halted         <= 1'b1;
                        dispatch_stall <= 1'b1;
                        illegal_seen   <= |(retire_valid & retire_illegal);
                    end else if (retire_branch) begin
                        state             <= ST_FLUSH;
                        flush             <= 1'b1;
                        dispatch_stall    <= 1'b1;
                        fetch_redirect_pc <= retire_branch_PC;
                    end
                end
                ST_FLUSH: begin
                    flush     <= 1'b0;
                    drain_cnt <= DW'(DRAIN_CYCLES - 1);
                    state     <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state                <= ST_REDIRECT;
                        fetch_redirect_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                ST_REDIRECT: begin
                    // Target stays put until fetch takes it.
                    if (fetch_redirect_ready) begin
                        state                <= ST_RUN;
                        fetch_redirect_valid <= 1'b0;
                        dispatch_stall       <= 1'b0;
                    end
                end
                ST_HALT: begin
                    // Terminal: only reset leaves.
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

`ifdef RECOVERY_PERF_EN
    logic [1:0]       perf_inc;
    logic [CNT_W-1:0] perf_cnt [2];

    // Index 0 counts FLUSH entries, index 1 counts stalled non-halt cycles.
    assign perf_inc[0] = (state == ST_RUN) && !halt_event && retire_branch;
    assign perf_inc[1] = dispatch_stall && (state != ST_HALT);

    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
        sat_counter #(.WIDTH(CNT_W)) u_cnt (
            .clock (clock),
            .reset (reset),
            .clear (1'b0),
            .inc   (perf_inc[gi]),
            .count (perf_cnt[gi])
        );
    end

    assign recovery_count = perf_cnt[0];
    assign stall_cycles   = perf_cnt[1];
`endif

endmodule
